// File: rtl/mul53_iter_ctrl.sv
// 53x53 unsigned significand multiply built from four passes through an external
// combinational 27x27 multiplier; partial products accumulate into a 106-bit result.
module mul53_iter_ctrl #(
  parameter int N_BITS = 53,
  parameter int SLICE  = 27
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic [SLICE-1:0]      mul_a,
  output logic [SLICE-1:0]      mul_b,
  input  logic [2*SLICE-1:0]    mul_p,
  output logic                  busy,
  output logic                  done,
  output logic [2*N_BITS-1:0]   p
);
  localparam int ACC_W = 2*N_BITS + 1;

  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3} state_t;

  state_t              r_state;
  logic [N_BITS-1:0]   r_a, r_b;
  logic [ACC_W-1:0]    r_acc;

  logic [SLICE-1:0]    w_al, w_ah, w_bl, w_bh;
  logic [ACC_W-1:0]    w_pp, w_pp_sh, w_sum;

  assign w_al = r_a[SLICE-1:0];
  assign w_bl = r_b[SLICE-1:0];
  // High halves are narrower than a slice; the shift leaves the top bits zero.
  assign w_ah = SLICE'(r_a >> SLICE);
  assign w_bh = SLICE'(r_b >> SLICE);

  assign w_pp = ACC_W'(mul_p);

  always_comb begin
    w_pp_sh = w_pp;
    case (r_state)
      PP1, PP2: w_pp_sh = w_pp << SLICE;
      PP3:      w_pp_sh = w_pp << (2*SLICE);
      default:  w_pp_sh = w_pp;
    endcase
  end

  assign w_sum = r_acc + w_pp_sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      p       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            mul_a   <= a[SLICE-1:0];
            mul_b   <= b[SLICE-1:0];
            busy    <= 1'b1;
            r_state <= PP0;
          end
        end
        PP0: begin
          r_acc   <= w_sum;
          mul_a   <= w_al;
          mul_b   <= w_bh;
          r_state <= PP1;
        end
        PP1: begin
          r_acc   <= w_sum;
          mul_a   <= w_ah;
          mul_b   <= w_bl;
          r_state <= PP2;
        end
        PP2: begin
          r_acc   <= w_sum;
          mul_a   <= w_ah;
          mul_b   <= w_bh;
          r_state <= PP3;
        end
        PP3: begin
          // Final sum always fits in 2*N_BITS, so the carry bit is dropped.
          p       <= w_sum[2*N_BITS-1:0];
          r_acc   <= w_sum;
          done    <= 1'b1;
          busy    <= 1'b0;
          mul_a   <= '0;
          mul_b   <= '0;
          r_state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
